// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Shift-and-add multiplier controller. It borrows the extended ALU to build
//   the low 16 bits of a 16x16 product, two cycles per multiplier bit: an ADD
//   cycle accumulates the multiplicand when the current multiplier bit is set,
//   and a SHIFT cycle doubles the multiplicand through the ALU.
//
//   Optional build macro: EARLY_EXIT_EN
//     Stops as soon as the remaining multiplier bits are all zero. A zero
//     multiplier goes from IDLE straight to DONE.
//
//   Parameter:
//     MAX_BITS        multiplier bits processed (1..16)
//
//   Ports:
//     clk, rst_n                 clock, synchronous active-low reset
//     in_valid/in_ready          operand request (in_ready high only in IDLE)
//     in_a, in_b                 multiplicand, multiplier
//     out_valid/out_ready        result handshake
//     out_result, out_zr, out_ng low 16 product bits, zero flag, sign flag
//     alu_x, alu_y, alu_instruction  operands and opcode driven to the ALU
//     alu_out                    ALU result (combinational from the above)
module alu_mul_sequencer #(
    parameter int MAX_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_zr,
    output logic        out_ng,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [8:0]  alu_instruction,
    input  logic [15:0] alu_out
);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    localparam logic [4:0]  LAST  = 5'(MAX_BITS);
    // Multiplier bits above MAX_BITS are dropped on load so the early-exit
    // zero test only sees bits that would actually be processed.
    localparam logic [15:0] BMASK = (MAX_BITS >= 16) ? 16'hFFFF
                                  : 16'((32'd1 << MAX_BITS) - 32'd1);
    localparam logic [8:0]  I_ADD = 9'b11_0_000010;   // x + y
    localparam logic [8:0]  I_SHL = 9'b01_0_110000;   // x <<< 1

    state_t      state;
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic [4:0]  cnt;

    logic [4:0]  cnt_nxt;
    logic [15:0] b_masked;
    logic        last_bit;

    assign cnt_nxt  = cnt + 5'd1;
    assign b_masked = in_b & BMASK;

`ifdef EARLY_EXIT_EN
    assign last_bit = (cnt_nxt == LAST) || ((mplier >> 1) == 16'h0);
`else
    assign last_bit = (cnt_nxt == LAST);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zr     <= 1'b1;
            out_ng     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is 1 throughout IDLE, so in_valid alone accepts
                    if (in_valid) begin
                        acc      <= '0;
                        mcand    <= in_a;
                        mplier   <= b_masked;
                        cnt      <= '0;
                        in_ready <= 1'b0;
`ifdef EARLY_EXIT_EN
                        if (b_masked == 16'h0) begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            out_result <= '0;
                            out_zr     <= 1'b1;
                            out_ng     <= 1'b0;
                        end else begin
                            state <= ADD;
                        end
`else
                        state <= ADD;
`endif
                    end
                end
                ADD: begin
                    if (mplier[0]) acc <= alu_out;
                    state <= SHIFT;
                end
                SHIFT: begin
                    mcand  <= alu_out;
                    mplier <= mplier >> 1;
                    cnt    <= cnt_nxt;
                    if (last_bit) begin
                        // acc is final here: the last ADD already happened
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= acc;
                        out_zr     <= (acc == 16'h0);
                        out_ng     <= acc[15];
                    end else begin
                        state <= ADD;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ALU drive is a pure decode of the current state and datapath registers.
    always_comb begin
        alu_x           = '0;
        alu_y           = '0;
        alu_instruction = '0;
        case (state)
            ADD: begin
                if (mplier[0]) begin
                    alu_x           = acc;
                    alu_y           = mcand;
                    alu_instruction = I_ADD;
                end
            end
            SHIFT: begin
                alu_x           = mcand;
                alu_instruction = I_SHL;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_zr, out_ng;
    logic [15:0] in_a, in_b, out_result, alu_x, alu_y, alu_out;
    logic [8:0]  alu_instruction;

    // second instance with a 4-bit multiplier
    logic        b4_in_valid, b4_in_ready, b4_out_valid, b4_out_ready, b4_out_zr, b4_out_ng;
    logic [15:0] b4_in_a, b4_in_b, b4_out_result, b4_alu_x, b4_alu_y, b4_alu_out;
    logic [8:0]  b4_alu_instruction;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    bit rnd = 0;

    typedef struct {
        logic [15:0] r;
        int          lat;
        int          t0;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: only the two opcodes the sequencer is allowed to use
    function automatic logic [15:0] alu_f(input logic [15:0] x, input logic [15:0] y,
                                          input logic [8:0] i);
        case (i)
            9'b110000010: return x + y;
            9'b010110000: return x << 1;
            default:      return 16'h0;
        endcase
    endfunction

    assign alu_out    = alu_f(alu_x, alu_y, alu_instruction);
    assign b4_alu_out = alu_f(b4_alu_x, b4_alu_y, b4_alu_instruction);

    alu_mul_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zr(out_zr), .out_ng(out_ng),
        .alu_x(alu_x), .alu_y(alu_y), .alu_instruction(alu_instruction), .alu_out(alu_out)
    );

    alu_mul_sequencer #(.MAX_BITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(b4_in_valid), .in_ready(b4_in_ready),
        .in_a(b4_in_a), .in_b(b4_in_b), .out_valid(b4_out_valid), .out_ready(b4_out_ready),
        .out_result(b4_out_result), .out_zr(b4_out_zr), .out_ng(b4_out_ng),
        .alu_x(b4_alu_x), .alu_y(b4_alu_y), .alu_instruction(b4_alu_instruction),
        .alu_out(b4_alu_out)
    );

    // ---------------- reference model ----------------
    function automatic logic [15:0] bmask(input logic [15:0] b, input int mb);
        logic [15:0] m;
        m = (mb >= 16) ? 16'hFFFF : 16'((32'd1 << mb) - 32'd1);
        return b & m;
    endfunction

    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input int mb);
        logic [31:0] p;
        p = 32'(a) * 32'(bmask(b, mb));
        return p[15:0];
    endfunction

    function automatic int lat_of(input logic [15:0] b, input int mb);
        int k;
        logic [15:0] bm;
        bm = bmask(b, mb);
`ifdef EARLY_EXIT_EN
        k = 0;
        for (int j = 0; j < mb; j++) if (bm[j]) k = j + 1;
`else
        k = mb;
`endif
        return 2 * k + 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"},  32'(out_valid), 0);
        chk({tag, "_out_result"}, 32'(out_result), 0);
        chk({tag, "_out_zr"},     32'(out_zr), 1);
        chk({tag, "_out_ng"},     32'(out_ng), 0);
        chk({tag, "_in_ready"},   32'(in_ready), 1);
        chk({tag, "_alu_x"},      32'(alu_x), 0);
        chk({tag, "_alu_y"},      32'(alu_y), 0);
        chk({tag, "_alu_instr"},  32'(alu_instruction), 0);
    endtask

    // Drive a request and push its expected response once it is accepted.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit sync, output int t0);
        int n;
        if (sync) @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            q.push_back('{ref_mul(a, b, 16), lat_of(b, 16), cyc});
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
    endtask

    // Walk the ADD/SHIFT cycles of a just-accepted request and check the ALU drive.
    task automatic trace(input logic [15:0] a, input logic [15:0] b);
        int k;
        logic [15:0] part, sh;
        k = (lat_of(b, 16) - 1) / 2;
        for (int i = 0; i < k; i++) begin
            part = ref_mul(a, b, i);
            sh   = a << i;
            @(negedge clk);
            chk($sformatf("add%0d_instr", i), 32'(alu_instruction), b[i] ? 32'h182 : 32'h0);
            if (b[i]) begin
                chk($sformatf("add%0d_x", i), 32'(alu_x), 32'(part));
                chk($sformatf("add%0d_y", i), 32'(alu_y), 32'(sh));
            end
            @(negedge clk);
            chk($sformatf("shl%0d_instr", i), 32'(alu_instruction), 32'h0B0);
            chk($sformatf("shl%0d_x", i), 32'(alu_x), 32'(sh));
        end
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 0);
        @(negedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit   pv;
        exp_t e;
        pv = 0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && !pv) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 0);
                end else begin
                    e = q.pop_front();
                    chk("result",  32'(out_result), 32'(e.r));
                    chk("zr",      32'(out_zr), 32'(e.r == 16'h0));
                    chk("ng",      32'(out_ng), 32'(e.r[15]));
                    chk("latency", 32'(cyc - e.t0), 32'(e.lat));
                end
            end
            pv = out_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0, t1, n, tn;
        logic [15:0] sa, sb, er, ra, rb;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        b4_in_valid = 1'b0; b4_in_a = '0; b4_in_b = '0; b4_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("rst0");
        chk("rst0_b4_in_ready", 32'(b4_in_ready), 1);
        rst_n = 1'b1;

        // 3 * 5 with ALU drive trace
        issue(16'd3, 16'd5, 1, t0);
        trace(16'd3, 16'd5);
        drain();

        // signed operand, then wrap; back-to-back spacing with out_ready high
        issue(16'hFFF9, 16'd6, 1, t0);
        issue(16'd300, 16'd300, 1, t1);
        chk("throughput", 32'(t1 - t0), 32'(lat_of(16'd6, 16) + 1));
        drain();

        // zero multiplier
        issue(16'd1234, 16'd0, 1, t0);
        drain();

        // stall with out_ready low; new requests must be ignored
        out_ready = 1'b0;
        sa = 16'h1357; sb = 16'h0246; er = ref_mul(sa, sb, 16);
        issue(sa, sb, 1, t0);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid_seen", 32'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
            chk("stall_valid",  32'(out_valid), 1);
            chk("stall_result", 32'(out_result), 32'(er));
            chk("stall_zr",     32'(out_zr), 32'(er == 16'h0));
            chk("stall_ng",     32'(out_ng), 32'(er[15]));
            chk("stall_ready",  32'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        chk("take_in_ready", 32'(in_ready), 0);
        tn = cyc;
        @(negedge clk);
        chk("idle_out_valid", 32'(out_valid), 0);
        chk("idle_in_ready",  32'(in_ready), 1);
        issue(16'd7, 16'd9, 0, t0);
        chk("accept_after_idle", 32'(t0 - tn), 1);
        drain();

        // reset in the middle of a product
        issue(16'hABCD, 16'h1234, 1, t0);
        n = 0;
        while (cyc < t0 + 12 && n < 50) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("midrst");
        rst_n = 1'b1;
        q.delete();
        repeat (40) @(negedge clk);
        issue(16'd2, 16'd2, 1, t0);
        drain();

        // randomized traffic with random out_ready back-pressure
        rnd = 1;
        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'h0;
                1:       rb = 16'($urandom) >> $urandom_range(8, 15);
                default: rb = 16'($urandom);
            endcase
            issue(ra, rb, 1, t0);
        end
        rnd = 0;
        drain();

        // MAX_BITS = 4 instance
        for (int i = 0; i < 6; i++) begin
            ra = (i == 0) ? 16'd5 : 16'($urandom);
            rb = (i == 0) ? 16'h0013 : 16'($urandom);
            @(negedge clk);
            chk("b4_in_ready", 32'(b4_in_ready), 1);
            b4_in_a = ra; b4_in_b = rb; b4_in_valid = 1'b1;
            t0 = cyc;
            @(posedge clk);
            #1;
            b4_in_valid = 1'b0; b4_in_a = 16'($urandom); b4_in_b = 16'($urandom);
            n = 0;
            while (!b4_out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("b4_result",  32'(b4_out_result), 32'(ref_mul(ra, rb, 4)));
            chk("b4_latency", 32'(cyc - t0), 32'(lat_of(rb, 4)));
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
